distance_delta: RTL and testbench

- Consumer end of the `distance_com` command stream issued per replica by the node controller.
- Decodes each `{pair, op}` command into a city pair, looks the pair up in a local distance table, and accumulates a signed delta tour length.
- Pulses the finished delta to the metropolis stage when a command burst ends.
- One instance per replica node.

---
 rtl/replica_pkg.sv | 26 ++
 rtl/distance_table.sv | 29 ++
 rtl/distance_delta.sv | 132 +++++++++++++
 tb/tb_distance_delta.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/replica_pkg.sv
// Command encodings shared between the node controller and the distance_delta consumer.
// Pair and op enums are fixed; the controller depends on these exact values.
package replica_pkg;

  typedef enum logic [2:0] {
    KN = 3'd0,
    KM = 3'd1,
    KP = 3'd2,
    LN = 3'd3,
    LP = 3'd4,
    LM = 3'd5
  } pair_e;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    MNS  = 2'd1,
    PLS  = 2'd2,
    DNOP = 2'd3
  } op_e;

  typedef struct packed {
    pair_e pair;
    op_e   op;
  } distance_command_t;

endpackage

// File: rtl/distance_table.sv
// Simple dual-port distance RAM: one write port, one registered read port, read-old on collision.
// Read data appears the cycle after the address; contents are never reset.
module distance_table #(
  parameter int DEPTH  = 1024,
  parameter int DIST_W = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DIST_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DIST_W-1:0] rdata_o
);

  logic [DIST_W-1:0] mem_q [DEPTH];
  logic [DIST_W-1:0] rdata_q;

  // Both statements sample mem_q before the edge, so a same-address read sees the old entry.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/distance_delta.sv
// Decodes {pair, op} commands, reads d(a,b) and accumulates a signed tour delta; 2-cycle latency,
// no backpressure (one command per cycle). DIST_PAIR_SORT_EN orders endpoints a<=b for reads and writes.
module distance_delta
  import replica_pkg::*;
#(
  parameter int CITY_NUM = 32,
  parameter int CITY_W   = $clog2(CITY_NUM),
  parameter int DIST_W   = 16,
  parameter int DELTA_W  = DIST_W + 3
) (
  input  logic                clk,
  input  logic                reset,
  input  distance_command_t   distance_com,
  input  logic [CITY_W-1:0]   city_km,
  input  logic [CITY_W-1:0]   city_k,
  input  logic [CITY_W-1:0]   city_kp,
  input  logic [CITY_W-1:0]   city_l,
  input  logic [CITY_W-1:0]   city_lp,
  input  logic                dist_we,
  input  logic [CITY_W-1:0]   dist_wa,
  input  logic [CITY_W-1:0]   dist_wb,
  input  logic [DIST_W-1:0]   dist_wdata,
  output logic [DELTA_W-1:0]  delta_distance,
  output logic                delta_valid,
  output logic                busy
);

  localparam int DEPTH  = CITY_NUM * CITY_NUM;
  localparam int ADDR_W = $clog2(DEPTH);

  function automatic logic [ADDR_W-1:0] pair_addr(input logic [CITY_W-1:0] a,
                                                  input logic [CITY_W-1:0] b);
    logic [CITY_W-1:0] row;
    logic [CITY_W-1:0] col;
`ifdef DIST_PAIR_SORT_EN
    row = (a <= b) ? a : b;
    col = (a <= b) ? b : a;
`else
    row = a;
    col = b;
`endif
    return ADDR_W'(row) * ADDR_W'(CITY_NUM) + ADDR_W'(col);
  endfunction

  logic [CITY_W-1:0]  pair_a;
  logic [CITY_W-1:0]  pair_b;
  op_e                op_d;
  logic [ADDR_W-1:0]  raddr;
  logic [ADDR_W-1:0]  waddr;
  logic [DIST_W-1:0]  rdata;

  op_e                op_rd_q;
  op_e                op_acc_q;
  logic [DELTA_W-1:0] acc_d;
  logic [DELTA_W-1:0] acc_q;
  logic               pending_d;
  logic               pending_q;
  logic               valid_d;
  logic               valid_q;

  // Unrecognised pair codes downgrade the op to DNOP so they never touch the accumulator.
  always_comb begin
    pair_a = city_km;
    pair_b = city_k;
    op_d   = distance_com.op;
    case (distance_com.pair)
      KM:      begin pair_a = city_km; pair_b = city_k;  end
      KP:      begin pair_a = city_km; pair_b = city_kp; end
      KN:      begin pair_a = city_k;  pair_b = city_lp; end
      LM:      begin pair_a = city_km; pair_b = city_l;  end
      LN:      begin pair_a = city_l;  pair_b = city_lp; end
      LP:      begin pair_a = city_l;  pair_b = city_k;  end
      default: op_d = DNOP;
    endcase
  end

  assign raddr = pair_addr(pair_a, pair_b);
  assign waddr = pair_addr(dist_wa, dist_wb);

  distance_table #(
    .DEPTH  (DEPTH),
    .DIST_W (DIST_W),
    .ADDR_W (ADDR_W)
  ) u_table (
    .clk     (clk),
    .we_i    (dist_we),
    .waddr_i (waddr),
    .wdata_i (dist_wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    acc_d     = acc_q;
    pending_d = pending_q;
    valid_d   = 1'b0;
    case (op_rd_q)
      ZERO:    acc_d = '0;
      PLS:     acc_d = acc_q + DELTA_W'(rdata);
      MNS:     acc_d = acc_q - DELTA_W'(rdata);
      default: acc_d = acc_q;
    endcase
    // The first DNOP after any accumulating op closes the burst.
    if (op_rd_q != DNOP) begin
      pending_d = 1'b1;
    end else if (pending_q) begin
      pending_d = 1'b0;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_rd_q   <= DNOP;
      op_acc_q  <= DNOP;
      acc_q     <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      op_rd_q   <= op_d;
      op_acc_q  <= op_rd_q;
      acc_q     <= acc_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
    end
  end

  assign delta_distance = acc_q;
  assign delta_valid    = valid_q;
  assign busy           = (op_rd_q != DNOP) || (op_acc_q != DNOP) || pending_q;

endmodule

// File: tb/tb_distance_delta.sv
// Directed bench for distance_delta: 2-opt/Or-opt bursts, burst separation, reset flush, read-old collision.
module tb_distance_delta;
  import replica_pkg::*;

  localparam int CITY_W  = 5;
  localparam int DIST_W  = 16;
  localparam int DELTA_W = 19;

  logic                clk = 1'b0;
  logic                reset;
  distance_command_t   distance_com;
  logic [CITY_W-1:0]   city_km, city_k, city_kp, city_l, city_lp;
  logic                dist_we;
  logic [CITY_W-1:0]   dist_wa, dist_wb;
  logic [DIST_W-1:0]   dist_wdata;
  logic [DELTA_W-1:0]  delta_distance;
  logic                delta_valid;
  logic                busy;

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  int base;

  distance_delta dut (
    .clk            (clk),
    .reset          (reset),
    .distance_com   (distance_com),
    .city_km        (city_km),
    .city_k         (city_k),
    .city_kp        (city_kp),
    .city_l         (city_l),
    .city_lp        (city_lp),
    .dist_we        (dist_we),
    .dist_wa        (dist_wa),
    .dist_wb        (dist_wb),
    .dist_wdata     (dist_wdata),
    .delta_distance (delta_distance),
    .delta_valid    (delta_valid),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (delta_valid === 1'b1) vcount++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input pair_e p, input op_e o);
    distance_com.pair = p;
    distance_com.op   = o;
    step();
  endtask

  task automatic wr(input logic [CITY_W-1:0] a, input logic [CITY_W-1:0] b,
                    input logic [DIST_W-1:0] d);
    dist_we    = 1'b1;
    dist_wa    = a;
    dist_wb    = b;
    dist_wdata = d;
    step();
    dist_we    = 1'b0;
  endtask

  task automatic burst_2opt();
    cmd(KM, ZERO);
    cmd(KM, MNS);
    cmd(LM, PLS);
    cmd(LN, MNS);
    cmd(KN, PLS);
    cmd(KM, DNOP);
  endtask

  initial begin
    reset        = 1'b1;
    distance_com = '{pair: KM, op: DNOP};
    dist_we      = 1'b0;
    dist_wa      = '0;
    dist_wb      = '0;
    dist_wdata   = '0;
    city_km = 5'd3; city_k = 5'd5; city_kp = 5'd7; city_l = 5'd9; city_lp = 5'd11;
    step();
    step();
    chk("reset_delta", 32'(delta_distance), 32'd0);
    chk("reset_valid", 32'(delta_valid), 32'd0);
    chk("reset_busy",  32'(busy), 32'd0);
    reset = 1'b0;

    wr(5'd3, 5'd5, 16'd10);
    wr(5'd5, 5'd7, 16'd4);
    wr(5'd3, 5'd7, 16'd20);
    wr(5'd9, 5'd11, 16'd6);
    wr(5'd9, 5'd5, 16'd7);
    wr(5'd3, 5'd9, 16'd8);
    wr(5'd5, 5'd11, 16'd9);

    // 2-opt: -10 + 8 - 6 + 9 = 1
    base = vcount;
    cmd(KM, ZERO);
    chk("2opt_busy_start", 32'(busy), 32'd1);
    cmd(KM, MNS);
    cmd(LM, PLS);
    cmd(LN, MNS);
    cmd(KN, PLS);
    cmd(KM, DNOP);
    chk("2opt_delta_early", 32'(delta_distance), 32'd1);
    chk("2opt_valid_early", 32'(delta_valid), 32'd0);
    cmd(KM, DNOP);
    chk("2opt_valid", 32'(delta_valid), 32'd1);
    chk("2opt_delta", 32'(delta_distance), 32'd1);
    chk("2opt_busy_low", 32'(busy), 32'd0);
    cmd(KM, DNOP);
    chk("2opt_valid_once", 32'(delta_valid), 32'd0);
    chk("2opt_busy_after", 32'(busy), 32'd0);
    chk("2opt_pulses", 32'(vcount - base), 32'd1);

    // Or-opt: -10 + 20 - 6 + 7 = 11
    base = vcount;
    cmd(KM, ZERO);
    cmd(KM, MNS);
    cmd(KP, PLS);
    cmd(LN, MNS);
    cmd(LP, PLS);
    cmd(KM, DNOP);
    chk("oropt_valid_early", 32'(delta_valid), 32'd0);
    cmd(KM, DNOP);
    chk("oropt_valid", 32'(delta_valid), 32'd1);
    chk("oropt_delta", 32'(delta_distance), 32'd11);
    cmd(KM, DNOP);
    cmd(KM, DNOP);
    chk("oropt_pulses", 32'(vcount - base), 32'd1);

    // Two bursts separated by single DNOPs: +10 then -20
    base = vcount;
    cmd(KM, ZERO);
    cmd(KM, PLS);
    cmd(KM, DNOP);
    chk("bb_valid_c3", 32'(delta_valid), 32'd0);
    cmd(KP, ZERO);
    chk("bb_valid1", 32'(delta_valid), 32'd1);
    chk("bb_delta1", 32'(delta_distance), 32'd10);
    cmd(KP, MNS);
    chk("bb_valid_c5", 32'(delta_valid), 32'd0);
    cmd(KM, DNOP);
    chk("bb_delta2_early", 32'(delta_distance), 32'h7FFEC);
    chk("bb_valid_c6", 32'(delta_valid), 32'd0);
    cmd(KM, DNOP);
    chk("bb_valid2", 32'(delta_valid), 32'd1);
    chk("bb_delta2", 32'(delta_distance), 32'h7FFEC);
    cmd(KM, DNOP);
    chk("bb_pulses", 32'(vcount - base), 32'd2);

    // Unknown pair code behaves as DNOP and closes the burst
    cmd(KM, ZERO);
    cmd(KM, PLS);
    distance_com = distance_command_t'(5'b111_10);
    step();
    cmd(KM, DNOP);
    chk("unk_valid", 32'(delta_valid), 32'd1);
    chk("unk_delta", 32'(delta_distance), 32'd10);
    cmd(KM, DNOP);
    cmd(KM, DNOP);

    // Reset during the third command of a burst
    base = vcount;
    cmd(KM, ZERO);
    cmd(KM, MNS);
    reset = 1'b1;
    distance_com = '{pair: LM, op: PLS};
    step();
    reset = 1'b0;
    distance_com = '{pair: KM, op: DNOP};
    chk("rst_delta", 32'(delta_distance), 32'd0);
    chk("rst_valid", 32'(delta_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    cmd(KM, DNOP);
    cmd(KM, DNOP);
    cmd(KM, DNOP);
    chk("rst_pulses", 32'(vcount - base), 32'd0);
    burst_2opt();
    cmd(KM, DNOP);
    chk("rst_after_valid", 32'(delta_valid), 32'd1);
    chk("rst_after_delta", 32'(delta_distance), 32'd1);
    cmd(KM, DNOP);

    // Write to (3,5) in the same cycle as the KM read returns the old entry
    cmd(KM, ZERO);
    dist_we    = 1'b1;
    dist_wa    = 5'd3;
    dist_wb    = 5'd5;
    dist_wdata = 16'd50;
    cmd(KM, PLS);
    dist_we    = 1'b0;
    cmd(KM, DNOP);
    cmd(KM, DNOP);
    chk("coll_valid", 32'(delta_valid), 32'd1);
    chk("coll_old", 32'(delta_distance), 32'd10);
    cmd(KM, ZERO);
    cmd(KM, PLS);
    cmd(KM, DNOP);
    cmd(KM, DNOP);
    chk("coll_new", 32'(delta_distance), 32'd50);

`ifdef DIST_PAIR_SORT_EN
    // Mirror-image write lands on the same entry
    wr(5'd5, 5'd3, 16'd12);
    cmd(KM, ZERO);
    cmd(KM, PLS);
    cmd(KM, DNOP);
    cmd(KM, DNOP);
    chk("sort_valid", 32'(delta_valid), 32'd1);
    chk("sort_delta", 32'(delta_distance), 32'd12);
`endif

    cmd(KM, DNOP);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
